// File: rtl/cpu_out_display.sv
// cpu_out_display
//   Watches the CPU's 8-bit output bus. When the value changes it is converted
//   to three BCD digits by a sequential double-dabble engine. The result is
//   shown on a 4-digit, active-low, multiplexed 7-segment display with
//   leading-zero blanking.
//
// Build option: define SIGNED_DISPLAY_EN to treat cpuOut as two's complement.
//   The magnitude is then converted, and digit 3 shows a minus sign for
//   negative values. Without the macro, cpuOut is unsigned and no sign logic
//   is built.
//
// Parameters
//   REFRESH_DIV  boardCLK cycles per digit slot
// Ports
//   boardCLK  in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   cpuOut    in   [7:0] value to display
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal point, active-low, always off
//   an        out  [3:0] anodes, active-low one-hot, an[0] = rightmost digit
//   busy      out  high while a conversion is running
//   bcdValue  out  [11:0] committed BCD {hundreds,tens,ones}
module cpu_out_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        boardCLK,
  input  logic        reset,
  input  logic [7:0]  cpuOut,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy,
  output logic [11:0] bcdValue
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      bin_q, bin_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      last_q, last_d;
  logic            busy_q, busy_d;
  logic [11:0]     val_q, val_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            sign_disp;
`ifdef SIGNED_DISPLAY_EN
  logic            sign_work_q, sign_work_d;
  logic            sign_q, sign_d;
`endif

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decade.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Conversion FSM and datapath
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    val_d   = val_q;
`ifdef SIGNED_DISPLAY_EN
    sign_work_d = sign_work_q;
    sign_d      = sign_q;
`endif
    case (state_q)
      IDLE: begin
        // Compare against the last captured value so changes that arrive
        // mid-conversion are picked up once the engine is free again.
        if (cpuOut != last_q) begin
`ifdef SIGNED_DISPLAY_EN
          bin_d       = cpuOut[7] ? (~cpuOut + 8'd1) : cpuOut;
          sign_work_d = cpuOut[7];
`else
          bin_d = cpuOut;
`endif
          bcd_d   = 12'h000;
          last_d  = cpuOut;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        val_d   = bcd_q;
        busy_d  = 1'b0;
`ifdef SIGNED_DISPLAY_EN
        sign_d  = sign_work_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SIGNED_DISPLAY_EN
  assign sign_disp = sign_q;
`else
  assign sign_disp = 1'b0;
`endif

  // Display multiplexing: slot timer, digit select and registered drivers
  always_comb begin
    ref_d = ref_q + RW'(1);
    sel_d = sel_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      sel_d = sel_q + 2'd1;
    end
    an_d  = ~(4'b0001 << sel_q);
    seg_d = SEG_BLANK;
    case (sel_q)
      2'd0: seg_d = seg_of(val_q[3:0]);
      2'd1: seg_d = (val_q[11:4] == 8'h00) ? SEG_BLANK : seg_of(val_q[7:4]);
      2'd2: seg_d = (val_q[11:8] == 4'h0) ? SEG_BLANK : seg_of(val_q[11:8]);
      default: seg_d = sign_disp ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  always_ff @(posedge boardCLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 8'h00;
      busy_q  <= 1'b0;
      val_q   <= 12'h000;
      ref_q   <= '0;
      sel_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
`ifdef SIGNED_DISPLAY_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      val_q   <= val_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
`ifdef SIGNED_DISPLAY_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // Working shift registers are always reloaded on capture before use
  always_ff @(posedge boardCLK) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
`ifdef SIGNED_DISPLAY_EN
    sign_work_q <= sign_work_d;
`endif
  end

  assign seg      = seg_q;
  assign dp       = 1'b1;
  assign an       = an_q;
  assign busy     = busy_q;
  assign bcdValue = val_q;

endmodule
